// File: rtl/reexe_pipe_pkg.sv
// Shared widths and defaults for the delayed-execution (re-exe) pipeline
// that sits between the issue stage and MEM.
package reexe_pipe_pkg;

    localparam int REEXE_DEPTH   = 2;
    localparam int GPR_NUM_W     = 5;
    localparam int SINGLE_WORD_W = 32;

    typedef logic [GPR_NUM_W-1:0]     gpr_num_t;
    typedef logic [SINGLE_WORD_W-1:0] single_word_t;

endpackage

// File: rtl/reexe_pipe_slot.sv
// One re-exe pipeline slot: state registers, load/hold/fill/clear muxing
// and the forwarding flags that issue uses for bypass.
module reexe_pipe_slot
    import reexe_pipe_pkg::*;
#(
    parameter int DATA_W = SINGLE_WORD_W,
    parameter int REG_W  = GPR_NUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              clear,
    input  logic              fill,
    input  logic              ld_pending,
    input  logic [REG_W-1:0]  ld_num,
    input  logic [DATA_W-1:0] ld_vaddr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [DATA_W-1:0] fill_data,
    output logic              valid,
    output logic              pending,
    output logic [REG_W-1:0]  num,
    output logic [DATA_W-1:0] vaddr,
    output logic [DATA_W-1:0] data,
    output logic              fwd_valid,
    output logic              fwd_ready
);

    // Payload is left untouched when the slot empties; valid gates every use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            pending <= 1'b0;
            num     <= '0;
            vaddr   <= '0;
            data    <= '0;
        end else if (flush) begin
            valid   <= 1'b0;
            pending <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            pending <= ld_pending;
            num     <= ld_num;
            vaddr   <= ld_vaddr;
            data    <= ld_data;
        end else if (clear) begin
            valid   <= 1'b0;
            pending <= 1'b0;
        end else if (fill) begin
            pending <= 1'b0;
            data    <= fill_data;
        end
    end

    assign fwd_valid = valid & (num != '0);
    assign fwd_ready = fwd_valid & ~pending;

endmodule

// File: rtl/reexe_pipe.sv
// DEPTH-slot delayed-execution pipeline with in-order late-result fill,
// flush, valid/allowin back-pressure and per-slot forwarding.
module reexe_pipe
    import reexe_pipe_pkg::*;
#(
    parameter int DEPTH  = REEXE_DEPTH,
    parameter int DATA_W = SINGLE_WORD_W,
    parameter int REG_W  = GPR_NUM_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid_i,
    output logic                    in_allowin_o,
    input  logic [REG_W-1:0]        in_writeNum_i,
    input  logic [DATA_W-1:0]       in_vaddr_i,
    input  logic [DATA_W-1:0]       in_data_i,
    input  logic                    in_pending_i,
    input  logic                    fill_valid_i,
    input  logic [DATA_W-1:0]       fill_data_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_allowin_i,
    output logic [REG_W-1:0]        out_writeNum_o,
    output logic [DATA_W-1:0]       out_vaddr_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic [DEPTH-1:0]        fwd_valid_o,
    output logic [DEPTH-1:0]        fwd_ready_o,
    output logic [DEPTH*REG_W-1:0]  fwd_num_o,
    output logic [DEPTH*DATA_W-1:0] fwd_data_o
);

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  load;
    logic [DEPTH-1:0]  move;
    logic [DEPTH-1:0]  fill_sel;
    logic [REG_W-1:0]  num   [DEPTH];
    logic [DATA_W-1:0] vaddr [DEPTH];
    logic [DATA_W-1:0] data  [DEPTH];
    logic              fire;

    assign out_valid_o    = valid[DEPTH-1] & ~pending[DEPTH-1] & ~flush_i;
    assign fire           = out_valid_o & out_allowin_i;
    assign out_writeNum_o = num[DEPTH-1];
    assign out_vaddr_o    = vaddr[DEPTH-1];
    assign out_data_o     = data[DEPTH-1];

    // Advance chain resolved from the oldest slot back toward the entry slot.
    always_comb begin
        logic down_moving;
        move             = '0;
        move[DEPTH-1]    = fire;
        down_moving      = fire;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            move[k]     = valid[k] & (~valid[k+1] | down_moving);
            down_moving = move[k];
        end
    end

    assign in_allowin_o = ~valid[0] | move[0];

    // Fills complete in order, so only the oldest pending slot can take one.
    always_comb begin
        logic found;
        fill_sel = '0;
        found    = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (!found && valid[k] && pending[k]) begin
                fill_sel[k] = fill_valid_i;
                found       = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic              ld_pending;
        logic [REG_W-1:0]  ld_num;
        logic [DATA_W-1:0] ld_vaddr;
        logic [DATA_W-1:0] ld_data;

        if (k == 0) begin : g_entry
            assign load[k]    = in_valid_i & in_allowin_o;
            assign ld_pending = in_pending_i;
            assign ld_num     = in_writeNum_i;
            assign ld_vaddr   = in_vaddr_i;
            assign ld_data    = in_pending_i ? '0 : in_data_i;
        end else begin : g_chain
            // A fill landing on a moving slot travels with it.
            assign load[k]    = move[k-1];
            assign ld_pending = pending[k-1] & ~fill_sel[k-1];
            assign ld_num     = num[k-1];
            assign ld_vaddr   = vaddr[k-1];
            assign ld_data    = fill_sel[k-1] ? fill_data_i : data[k-1];
        end

        reexe_pipe_slot #(
            .DATA_W (DATA_W),
            .REG_W  (REG_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush_i),
            .load       (load[k]),
            .clear      (move[k] & ~load[k]),
            .fill       (fill_sel[k]),
            .ld_pending (ld_pending),
            .ld_num     (ld_num),
            .ld_vaddr   (ld_vaddr),
            .ld_data    (ld_data),
            .fill_data  (fill_data_i),
            .valid      (valid[k]),
            .pending    (pending[k]),
            .num        (num[k]),
            .vaddr      (vaddr[k]),
            .data       (data[k]),
            .fwd_valid  (fwd_valid_o[k]),
            .fwd_ready  (fwd_ready_o[k])
        );

        assign fwd_num_o[k*REG_W +: REG_W]    = num[k];
        assign fwd_data_o[k*DATA_W +: DATA_W] = data[k];
    end

endmodule

// File: tb/tb_reexe_pipe.sv
// Directed bench for reexe_pipe at DEPTH=2: latency, back-pressure, pending
// fill, flush, zero-destination forwarding and asynchronous reset.
module tb_reexe_pipe;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic                    clk;
    logic                    rst;
    logic                    in_valid_i;
    logic                    in_allowin_o;
    logic [REG_W-1:0]        in_writeNum_i;
    logic [DATA_W-1:0]       in_vaddr_i;
    logic [DATA_W-1:0]       in_data_i;
    logic                    in_pending_i;
    logic                    fill_valid_i;
    logic [DATA_W-1:0]       fill_data_i;
    logic                    flush_i;
    logic                    out_valid_o;
    logic                    out_allowin_i;
    logic [REG_W-1:0]        out_writeNum_o;
    logic [DATA_W-1:0]       out_vaddr_o;
    logic [DATA_W-1:0]       out_data_o;
    logic [DEPTH-1:0]        fwd_valid_o;
    logic [DEPTH-1:0]        fwd_ready_o;
    logic [DEPTH*REG_W-1:0]  fwd_num_o;
    logic [DEPTH*DATA_W-1:0] fwd_data_o;

    int total;
    int bad;

    reexe_pipe #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid_i),
        .in_allowin_o   (in_allowin_o),
        .in_writeNum_i  (in_writeNum_i),
        .in_vaddr_i     (in_vaddr_i),
        .in_data_i      (in_data_i),
        .in_pending_i   (in_pending_i),
        .fill_valid_i   (fill_valid_i),
        .fill_data_i    (fill_data_i),
        .flush_i        (flush_i),
        .out_valid_o    (out_valid_o),
        .out_allowin_i  (out_allowin_i),
        .out_writeNum_o (out_writeNum_o),
        .out_vaddr_o    (out_vaddr_o),
        .out_data_o     (out_data_o),
        .fwd_valid_o    (fwd_valid_o),
        .fwd_ready_o    (fwd_ready_o),
        .fwd_num_o      (fwd_num_o),
        .fwd_data_o     (fwd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [REG_W-1:0] n, input logic [DATA_W-1:0] d,
                        input logic p);
        in_valid_i    = 1'b1;
        in_writeNum_i = n;
        in_data_i     = d;
        in_vaddr_i    = 32'h1000 + {27'd0, n};
        in_pending_i  = p;
    endtask

    task automatic idle();
        in_valid_i   = 1'b0;
        in_pending_i = 1'b0;
        fill_valid_i = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid_o); end
        total++; if (fwd_valid_o !== 2'b00) begin bad++; $display("FAIL rst_fwd_valid got=%0h exp=0", fwd_valid_o); end
        total++; if (fwd_ready_o !== 2'b00) begin bad++; $display("FAIL rst_fwd_ready got=%0h exp=0", fwd_ready_o); end
        total++; if (in_allowin_o !== 1'b1) begin bad++; $display("FAIL rst_in_allowin got=%0h exp=1", in_allowin_o); end
        total++; if (out_data_o !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%0h exp=0", out_data_o); end
        total++; if (fwd_num_o !== 10'h0) begin bad++; $display("FAIL rst_fwd_num got=%0h exp=0", fwd_num_o); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_latency();
        out_allowin_i = 1'b1;
        send(5'd3, 32'h11, 1'b0);
        step();
        idle();
        total++; if (fwd_valid_o !== 2'b01) begin bad++; $display("FAIL lat_c1_fwd_valid got=%0h exp=1", fwd_valid_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL lat_c1_out_valid got=%0h exp=0", out_valid_o); end
        step();
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL lat_c2_out_valid got=%0h exp=1", out_valid_o); end
        total++; if (out_data_o !== 32'h11) begin bad++; $display("FAIL lat_c2_out_data got=%0h exp=11", out_data_o); end
        total++; if (out_writeNum_o !== 5'd3) begin bad++; $display("FAIL lat_c2_out_num got=%0h exp=3", out_writeNum_o); end
        total++; if (out_vaddr_o !== 32'h1003) begin bad++; $display("FAIL lat_c2_out_vaddr got=%0h exp=1003", out_vaddr_o); end
        total++; if (fwd_valid_o !== 2'b10) begin bad++; $display("FAIL lat_c2_fwd_valid got=%0h exp=2", fwd_valid_o); end
        step();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL lat_c3_drained got=%0h exp=0", out_valid_o); end
    endtask

    task automatic test_back_to_back();
        out_allowin_i = 1'b0;
        send(5'd1, 32'hA, 1'b0);
        step();
        send(5'd2, 32'hB, 1'b0);
        step();
        idle();
        total++; if (in_allowin_o !== 1'b0) begin bad++; $display("FAIL b2b_full_allowin got=%0h exp=0", in_allowin_o); end
        total++; if (fwd_num_o !== {5'd1, 5'd2}) begin bad++; $display("FAIL b2b_fwd_num got=%0h exp=%0h", fwd_num_o, {5'd1, 5'd2}); end
        step();
        total++; if (out_data_o !== 32'hA) begin bad++; $display("FAIL b2b_hold_data got=%0h exp=a", out_data_o); end
        total++; if (fwd_data_o !== {32'hA, 32'hB}) begin bad++; $display("FAIL b2b_hold_fwd_data got=%0h exp=a0000000b", fwd_data_o); end
        out_allowin_i = 1'b1;
        #1;
        total++; if (in_allowin_o !== 1'b1) begin bad++; $display("FAIL b2b_release_allowin got=%0h exp=1", in_allowin_o); end
        step();
        total++; if (out_valid_o !== 1'b1 || out_data_o !== 32'hB) begin bad++; $display("FAIL b2b_second got=%0h/%0h exp=1/b", out_valid_o, out_data_o); end
        total++; if (out_writeNum_o !== 5'd2) begin bad++; $display("FAIL b2b_second_num got=%0h exp=2", out_writeNum_o); end
        step();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%0h exp=0", out_valid_o); end
    endtask

    task automatic test_pending();
        out_allowin_i = 1'b1;
        send(5'd5, 32'h99, 1'b1);
        step();
        idle();
        total++; if (fwd_ready_o !== 2'b00) begin bad++; $display("FAIL pend_c1_ready got=%0h exp=0", fwd_ready_o); end
        total++; if (fwd_data_o[31:0] !== 32'h0) begin bad++; $display("FAIL pend_c1_data got=%0h exp=0", fwd_data_o[31:0]); end
        step();
        step();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL pend_block_out_valid got=%0h exp=0", out_valid_o); end
        total++; if (fwd_valid_o !== 2'b10 || fwd_ready_o !== 2'b00) begin bad++; $display("FAIL pend_block_fwd got=%0h/%0h exp=2/0", fwd_valid_o, fwd_ready_o); end
        fill_valid_i = 1'b1;
        fill_data_i  = 32'h55;
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL pend_fill_comb got=%0h exp=0", out_valid_o); end
        step();
        fill_valid_i = 1'b0;
        total++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h55) begin bad++; $display("FAIL pend_filled got=%0h/%0h exp=1/55", out_valid_o, out_data_o); end
        total++; if (fwd_ready_o !== 2'b10) begin bad++; $display("FAIL pend_filled_ready got=%0h exp=2", fwd_ready_o); end
        step();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL pend_drained got=%0h exp=0", out_valid_o); end
    endtask

    task automatic test_two_pending();
        out_allowin_i = 1'b1;
        send(5'd6, 32'h0, 1'b1);
        step();
        send(5'd7, 32'h0, 1'b1);
        fill_valid_i = 1'b1;
        fill_data_i  = 32'h66;
        step();
        idle();
        total++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h66) begin bad++; $display("FAIL two_oldest got=%0h/%0h exp=1/66", out_valid_o, out_data_o); end
        total++; if (fwd_valid_o !== 2'b11 || fwd_ready_o !== 2'b10) begin bad++; $display("FAIL two_fwd got=%0h/%0h exp=3/2", fwd_valid_o, fwd_ready_o); end
        step();
        total++; if (out_valid_o !== 1'b0 || out_writeNum_o !== 5'd7) begin bad++; $display("FAIL two_young_pending got=%0h/%0h exp=0/7", out_valid_o, out_writeNum_o); end
        fill_valid_i = 1'b1;
        fill_data_i  = 32'h77;
        step();
        fill_valid_i = 1'b0;
        total++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h77) begin bad++; $display("FAIL two_young_filled got=%0h/%0h exp=1/77", out_valid_o, out_data_o); end
        step();
    endtask

    task automatic test_stray_fill_and_flush();
        out_allowin_i = 1'b0;
        send(5'd8, 32'h88, 1'b0);
        step();
        idle();
        fill_valid_i = 1'b1;
        fill_data_i  = 32'hDEAD;
        send(5'd9, 32'h99, 1'b0);
        step();
        idle();
        total++; if (out_data_o !== 32'h88 || fwd_data_o[31:0] !== 32'h99) begin bad++; $display("FAIL stray_fill got=%0h/%0h exp=88/99", out_data_o, fwd_data_o[31:0]); end
        out_allowin_i = 1'b1;
        flush_i = 1'b1;
        send(5'd10, 32'hAA, 1'b0);
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_force_out got=%0h exp=0", out_valid_o); end
        step();
        idle();
        total++; if (fwd_valid_o !== 2'b00 || out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_cleared got=%0h/%0h exp=0/0", fwd_valid_o, out_valid_o); end
        step();
        total++; if (fwd_valid_o !== 2'b00 || out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_no_capture got=%0h/%0h exp=0/0", fwd_valid_o, out_valid_o); end
    endtask

    task automatic test_zero_num_and_reset();
        out_allowin_i = 1'b1;
        send(5'd0, 32'h12, 1'b0);
        step();
        idle();
        total++; if (fwd_valid_o !== 2'b00 || fwd_ready_o !== 2'b00) begin bad++; $display("FAIL zero_c1_fwd got=%0h/%0h exp=0/0", fwd_valid_o, fwd_ready_o); end
        out_allowin_i = 1'b0;
        send(5'd4, 32'h44, 1'b0);
        step();
        idle();
        total++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h12) begin bad++; $display("FAIL zero_out got=%0h/%0h exp=1/12", out_valid_o, out_data_o); end
        total++; if (fwd_valid_o !== 2'b01) begin bad++; $display("FAIL zero_fwd_mix got=%0h exp=1", fwd_valid_o); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0 || fwd_valid_o !== 2'b00) begin bad++; $display("FAIL async_rst_valid got=%0h/%0h exp=0/0", out_valid_o, fwd_valid_o); end
        total++; if (in_allowin_o !== 1'b1 || out_data_o !== 32'h0) begin bad++; $display("FAIL async_rst_state got=%0h/%0h exp=1/0", in_allowin_o, out_data_o); end
        rst = 1'b1;
        step();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        in_valid_i    = 1'b0;
        in_writeNum_i = '0;
        in_vaddr_i    = '0;
        in_data_i     = '0;
        in_pending_i  = 1'b0;
        fill_valid_i  = 1'b0;
        fill_data_i   = '0;
        flush_i       = 1'b0;
        out_allowin_i = 1'b1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_pending();
        test_two_pending();
        test_stray_fill_and_flush();
        test_zero_num_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
